i2c_scl_timebase: RTL and testbench
===================================

# i2c_scl_timebase

Parametrised I2C bit-timing generator, successor to the fixed 400 kHz divider. Produces single-cycle quarter-period enable strobes, a phase index and an SCL drive level from one system clock. Speed is run-time selectable (100 kHz, 400 kHz, 1 MHz or a custom divider), with optional clock-stretch hold. It feeds the I2C master FSM, which advances only on `tick`; no derived clocks are generated.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency, used to compute the per-mode dividers.
- `CNT_W`, 12: quarter-period counter width; every computed divider must fit, checked at elaboration.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; low means idle (bus released).
- `mode`  in  2  speed select, type `i2c_speed_e`: 0=STD 100k, 1=FAST 400k, 2=FASTPLUS 1M, 3=CUSTOM.
- `div_custom`  in  CNT_W  quarter-period length in clk cycles, used only when mode=CUSTOM.
- `scl_in`  in  1  SCL as seen on the bus; asynchronous.
- `tick`  out  1  one-cycle strobe at the end of each quarter period.
- `phase`  out  2  current quarter: 0 and 1 are SCL low, 2 and 3 are SCL high.
- `scl_out`  out  1  SCL drive level: 1 = release, 0 = pull low.
- `stretched`  out  1  high while the end of phase 2 is held by a slave.
- `cfg_err`  out  1  latched divider was clamped.

## Operation
- Quarter divider `qdiv = ceil(CLK_FREQ_HZ / (4*f))`. Defaults give STD=250, FAST=63, FASTPLUS=25. The rounding guarantees the SCL frequency never exceeds nominal.
- CUSTOM uses `div_custom`. Any value below `MIN_QDIV` (4) is clamped to 4, and `cfg_err` is set.
- Configuration latch (`div_q`, `cfg_err`):
  - updated every cycle while `en`=0;
  - updated on the tick that ends phase 3;
  - never updated at any other time. A mode change mid-period takes effect at the next period boundary.
- Counter `cnt` holds `div_q-1` while idle and decrements each cycle while `en`=1.
- `tick` is the combinational decode `en & cnt==0 & !hold`.
- On each tick:
  - `cnt` reloads to `div_q-1`;
  - `phase` increments and wraps 3→0;
  - `scl_out` takes the value for the new phase: 0 for phases 0/1, 1 for phases 2/3.
- Phases as an FSM: Q0 (SCL low, data change) → Q1 (SCL low) → Q2 (SCL high) → Q3 (SCL high, sample) → Q0.
- Idle is entered from any phase when `en`=0, effective on the next edge: `phase`=0, `scl_out`=1, `cnt`=`div_q-1`, `stretched`=0.
- Reset values: `tick`=0, `phase`=0, `scl_out`=1, `stretched`=0, `cfg_err`=0, `cnt`=STD qdiv-1, `div_q`=STD.
- Reset mid-operation aborts the period immediately. There is no partial tick.

## Timing
- The first tick occurs in the `div_q`-th consecutive cycle with `en`=1. Thereafter ticks come every `div_q` cycles, so the SCL period is `4*div_q` cycles with a 50% duty cycle.
- `phase` and `scl_out` change on the edge that closes the tick cycle. Their latency from `tick` is 1 edge.
- `en` falling in the same cycle as a tick: the tick is not emitted, because `tick` requires `en`, and the block goes idle.
- Stretch hold:
  - `hold` is defined as `phase==2 & cnt==0 & scl_sync==0`.
  - While `hold` is set, `cnt` stays at 0, no tick is issued, and `stretched`=1.
  - The tick is issued in the first cycle `scl_sync`=1.
  - `scl_sync` lags `scl_in` by 2 cycles. `MIN_QDIV`=4 guarantees the block's own SCL release is visible before phase 2 ends.

## Configuration
- `I2C_STRETCH_EN` defined: the 2-flop synchronizer and the stretch hold described above are built.
- Without the macro:
  - `scl_in` is unused;
  - `hold` is tied to 0 and `stretched` to 0;
  - phase 2 always lasts exactly `div_q` cycles.

## Structure
- The shared package `i2c_pkg` holds:
  - the `i2c_speed_e` enum;
  - the constants `F_STD`=100_000, `F_FAST`=400_000, `F_FASTPLUS`=1_000_000 and `MIN_QDIV`=4;
  - the function `qdiv_calc(clk_hz, f)` (ceil division).
- One sub-module, `sync_2ff`, is the single-bit 2-stage synchronizer for `scl_in`. It is instantiated only under `I2C_STRETCH_EN`.

## Test plan
- Reset: assert `rst` for 3 cycles with `en`=0. Required: `tick`=0, `phase`=0, `scl_out`=1, `stretched`=0, `cfg_err`=0.
- FAST: `mode`=1, `en`=1. Required: first tick in cycle 63, then every 63 cycles; `scl_out` low 126 cycles and high 126 cycles; `phase` sequence 0,1,2,3,0.
- CUSTOM clamp: `mode`=3, `div_custom`=2. Required: `cfg_err`=1 and a tick every 4 cycles. Then, while idle, set `div_custom`=10: required `cfg_err`=0 and a tick every 10 cycles.
- Mode change: running STD, switch to FASTPLUS during phase 1. Required: phases 1–3 stay at 250 cycles each; quarters become 25 cycles from the next phase 0.
- Stretch (with `I2C_STRETCH_EN`): hold `scl_in`=0 for 100 cycles from the start of phase 2. Required: `stretched`=1 from the last count of phase 2; the tick comes 2 cycles after `scl_in` rises; phase 3 then lasts the full `div_q`. Without the macro, the same stimulus leaves timing unchanged.
- Abort: drop `en` in the middle of phase 2, then re-assert it after 5 cycles. Required: next edge `phase`=0, `scl_out`=1, no tick; after re-enable, the first tick comes after the full `div_q` cycles.

Source files
------------

// File: rtl/i2c_scl_timebase_pkg.sv
// Shared I2C timing types, nominal bus rates and divider helper.
package i2c_pkg;

  typedef enum logic [1:0] {
    SPD_STD      = 2'd0,
    SPD_FAST     = 2'd1,
    SPD_FASTPLUS = 2'd2,
    SPD_CUSTOM   = 2'd3
  } i2c_speed_e;

  typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} phase_e;

  localparam int unsigned F_STD      = 100_000;
  localparam int unsigned F_FAST     = 400_000;
  localparam int unsigned F_FASTPLUS = 1_000_000;
  localparam int unsigned MIN_QDIV   = 4;

  // Rounds up so the generated SCL never runs faster than nominal.
  function automatic int unsigned qdiv_calc(input int unsigned clk_hz, input int unsigned f);
    return (clk_hz + 4 * f - 1) / (4 * f);
  endfunction

endpackage

// File: rtl/i2c_scl_timebase_if.sv
// Control/status bundle between the I2C master FSM and the SCL timebase.
interface i2c_scl_timebase_if #(parameter int CNT_W = 12);
  import i2c_pkg::*;

  logic             en;
  i2c_speed_e       mode;
  logic [CNT_W-1:0] div_custom;
  logic             scl_in;
  logic             tick;
  logic [1:0]       phase;
  logic             scl_out;
  logic             stretched;
  logic             cfg_err;

  modport master (output en, mode, div_custom, scl_in,
                  input  tick, phase, scl_out, stretched, cfg_err);
  modport slave  (input  en, mode, div_custom, scl_in,
                  output tick, phase, scl_out, stretched, cfg_err);
endinterface

// File: rtl/i2c_scl_timebase_sync_2ff.sv
// Single-bit two-flop synchronizer for the asynchronous SCL bus sample.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) ff_q <= {2{RST_VAL}};
    else     ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/i2c_scl_timebase.sv
// I2C quarter-period tick / phase / SCL level generator.
// Optional slave clock-stretch hold is built when I2C_STRETCH_EN is defined.
module i2c_scl_timebase
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int          CNT_W       = 12
) (
  input logic               clk,
  input logic               rst,
  i2c_scl_timebase_if.slave bus
);
  localparam int unsigned QD_STD = qdiv_calc(CLK_FREQ_HZ, F_STD);
  localparam int unsigned QD_FST = qdiv_calc(CLK_FREQ_HZ, F_FAST);
  localparam int unsigned QD_FPL = qdiv_calc(CLK_FREQ_HZ, F_FASTPLUS);

  if ((QD_STD >> CNT_W) != 0 || (QD_FST >> CNT_W) != 0 || (QD_FPL >> CNT_W) != 0 ||
      (MIN_QDIV >> CNT_W) != 0) begin : g_div_range
    $error("i2c_scl_timebase: divider does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DIV_STD = CNT_W'(QD_STD);
  localparam logic [CNT_W-1:0] DIV_FST = CNT_W'(QD_FST);
  localparam logic [CNT_W-1:0] DIV_FPL = CNT_W'(QD_FPL);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(MIN_QDIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, div_sel;
  logic             err_q, err_d, err_sel;
  phase_e           phase_q, phase_d;
  logic             scl_q, scl_d;
  logic             hold, tick, cfg_upd;

`ifdef I2C_STRETCH_EN
  logic scl_sync;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.scl_in),
    .q_o (scl_sync)
  );

  assign hold = bus.en & (phase_q == Q2) & (cnt_q == '0) & ~scl_sync;
`else
  logic unused_scl_in;
  assign unused_scl_in = bus.scl_in;
  assign hold          = 1'b0;
`endif

  always_comb begin
    div_sel = DIV_STD;
    err_sel = 1'b0;
    case (bus.mode)
      SPD_STD:      div_sel = DIV_STD;
      SPD_FAST:     div_sel = DIV_FST;
      SPD_FASTPLUS: div_sel = DIV_FPL;
      SPD_CUSTOM: begin
        if (bus.div_custom < DIV_MIN) begin
          div_sel = DIV_MIN;
          err_sel = 1'b1;
        end else begin
          div_sel = bus.div_custom;
        end
      end
      default:      div_sel = DIV_STD;
    endcase
  end

  // Config only moves while idle or on the period boundary, so a period never mixes speeds.
  always_comb begin
    tick    = bus.en & (cnt_q == '0) & ~hold;
    cfg_upd = ~bus.en | (tick & (phase_q == Q3));
    div_d   = cfg_upd ? div_sel : div_q;
    err_d   = cfg_upd ? err_sel : err_q;
    phase_d = phase_q;
    scl_d   = scl_q;
    cnt_d   = cnt_q;
    if (!bus.en) begin
      phase_d = Q0;
      scl_d   = 1'b1;
      cnt_d   = div_d - ONE;
    end else if (tick) begin
      case (phase_q)
        Q0:      phase_d = Q1;
        Q1:      phase_d = Q2;
        Q2:      phase_d = Q3;
        default: phase_d = Q0;
      endcase
      scl_d = (phase_d == Q2) || (phase_d == Q3);
      cnt_d = div_d - ONE;
    end else if (!hold) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= Q0;
      scl_q   <= 1'b1;
      cnt_q   <= DIV_STD - ONE;
      div_q   <= DIV_STD;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      scl_q   <= scl_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      err_q   <= err_d;
    end
  end

  assign bus.tick      = tick;
  assign bus.phase     = phase_q;
  assign bus.scl_out   = scl_q;
  assign bus.stretched = hold;
  assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_i2c_scl_timebase.sv
// Directed bench for i2c_scl_timebase at 100 MHz (STD=250, FAST=63, FASTPLUS=25).
module tb_i2c_scl_timebase;
  import i2c_pkg::*;

  logic clk;
  logic rst;
  logic ext_low;
  int   checks;
  int   passes;
  int   n;

  i2c_scl_timebase_if #(.CNT_W(12)) bus ();

  i2c_scl_timebase #(.CLK_FREQ_HZ(100_000_000), .CNT_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Open-drain bus: low if we pull it or the external slave holds it.
  assign bus.scl_in = bus.scl_out & ~ext_low;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Returns the 1-based cycle index of the next tick (0 on timeout); leaves us in the cycle after it.
  task automatic run_to_tick(input int max, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      #1;
      if (bus.tick) begin
        cyc = i;
        step();
        return;
      end
      step();
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    ext_low = 1'b0;
    bus.en = 1'b0;
    bus.mode = SPD_STD;
    bus.div_custom = '0;
    repeat (3) step();
    #1;
    chk("rst_tick", bus.tick, 0);
    chk("rst_phase", bus.phase, 0);
    chk("rst_scl", bus.scl_out, 1);
    chk("rst_stretched", bus.stretched, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    rst = 1'b0;
    step();

    // FAST: 63-cycle quarters
    bus.mode = SPD_FAST;
    step();
    bus.en = 1'b1;
    run_to_tick(400, n); chk("fast_q0_len", n, 63);
    chk("fast_ph1", bus.phase, 1); chk("fast_scl_ph1", bus.scl_out, 0);
    run_to_tick(400, n); chk("fast_q1_len", n, 63);
    chk("fast_ph2", bus.phase, 2); chk("fast_scl_ph2", bus.scl_out, 1);
    run_to_tick(400, n); chk("fast_q2_len", n, 63);
    chk("fast_ph3", bus.phase, 3); chk("fast_scl_ph3", bus.scl_out, 1);
    run_to_tick(400, n); chk("fast_q3_len", n, 63);
    chk("fast_ph0", bus.phase, 0); chk("fast_scl_ph0", bus.scl_out, 0);

    // CUSTOM clamp 2 -> 4, then 10
    bus.en = 1'b0;
    bus.mode = SPD_CUSTOM;
    bus.div_custom = 12'd2;
    step();
    chk("clamp_cfg_err", bus.cfg_err, 1);
    chk("idle_phase", bus.phase, 0);
    chk("idle_scl", bus.scl_out, 1);
    bus.en = 1'b1;
    run_to_tick(400, n); chk("clamp_q_a", n, 4);
    run_to_tick(400, n); chk("clamp_q_b", n, 4);
    bus.en = 1'b0;
    bus.div_custom = 12'd10;
    step();
    chk("custom10_cfg_err", bus.cfg_err, 0);
    bus.en = 1'b1;
    run_to_tick(400, n); chk("custom10_q_a", n, 10);
    run_to_tick(400, n); chk("custom10_q_b", n, 10);

    // STD, switch to FASTPLUS during phase 1
    bus.en = 1'b0;
    bus.mode = SPD_STD;
    step();
    bus.en = 1'b1;
    run_to_tick(400, n); chk("std_q0", n, 250);
    chk("std_ph1", bus.phase, 1);
    bus.mode = SPD_FASTPLUS;
    run_to_tick(400, n); chk("chg_q1", n, 250);
    run_to_tick(400, n); chk("chg_q2", n, 250);
    run_to_tick(400, n); chk("chg_q3", n, 250);
    chk("chg_ph0", bus.phase, 0);
    run_to_tick(400, n); chk("fp_q0", n, 25);
    run_to_tick(400, n); chk("fp_q1", n, 25);
    chk("fp_ph2", bus.phase, 2);

    // Slave holds SCL low for 100 cycles from the start of phase 2
    ext_low = 1'b1;
`ifdef I2C_STRETCH_EN
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      #1;
      if (bus.tick) n++;
      if (i == 24) chk("str_pre", bus.stretched, 0);
      if (i == 25) chk("str_on", bus.stretched, 1);
      step();
    end
    chk("str_no_tick", n, 0);
    ext_low = 1'b0;
    run_to_tick(400, n); chk("str_release", n, 3);
    chk("str_ph3", bus.phase, 3);
    #1; chk("str_off", bus.stretched, 0);
    run_to_tick(400, n); chk("str_q3", n, 25);
    chk("str_ph0", bus.phase, 0);
`else
    run_to_tick(400, n); chk("nostr_q2", n, 25);
    chk("nostr_ph3", bus.phase, 3);
    #1; chk("nostr_stretched", bus.stretched, 0);
    ext_low = 1'b0;
`endif

    // Abort: drop en on the last cycle of phase 2
    for (int k = 0; k < 4 && bus.phase != 2'd2; k++) run_to_tick(400, n);
    chk("abort_at_ph2", bus.phase, 2);
    repeat (24) step();
    bus.en = 1'b0;
    #1; chk("abort_no_tick", bus.tick, 0);
    step();
    chk("abort_phase", bus.phase, 0);
    chk("abort_scl", bus.scl_out, 1);
    chk("abort_stretched", bus.stretched, 0);
    repeat (4) step();
    bus.en = 1'b1;
    run_to_tick(400, n); chk("reen_q0", n, 25);
    chk("reen_ph1", bus.phase, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
